// File: rtl/scan_pkg.sv
// Shared definitions for the LED scan monitor: state encoding and default bus sizes.
package scan_pkg;

    localparam int WIDTH_DEF = 18;
    localparam int POSW_DEF  = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACQ  = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_ERR  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary index encoder with a legality flag.
module onehot_enc #(
    parameter int WIDTH = 18,
    parameter int POSW  = 5
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [POSW-1:0]  o_idx,
    output logic             o_onehot
);

    logic [WIDTH-1:0] w_low;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign w_low    = i_vec & (i_vec - WIDTH'(1));
    assign o_onehot = (i_vec != '0) && (w_low == '0);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_idx = o_idx | POSW'(i);
        end
    end

endmodule

// File: rtl/scan_monitor.sv
// Locks onto a bouncing one-hot LED scan, tracks position/direction, counts end
// reversals and flags any step the scan pattern could not legally make.
module scan_monitor
    import scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int POSW  = POSW_DEF
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] qin,
    output logic [POSW-1:0]  pos,
    output logic             dir,
    output logic             valid,
    output logic             bounce,
    output logic [7:0]       sweeps,
    output logic             err
);

    localparam logic [POSW:0] TOP = (POSW+1)'(WIDTH - 1);
    localparam logic [POSW:0] ONE = (POSW+1)'(1);

    scan_state_t     r_state;
    logic [POSW-1:0] r_pos;
    logic            r_dir, r_valid, r_bounce, r_err;
    logic [7:0]      r_sweeps;

    scan_state_t     w_state_n;
    logic [POSW-1:0] w_pos_n;
    logic            w_bounce_n;
    logic [POSW-1:0] w_idx;
    logic            w_oh;
    logic [POSW:0]   w_idx_x, w_pos_x;
    logic            w_fwd, w_bwd, w_same, w_top, w_bot;

    onehot_enc #(.WIDTH(WIDTH), .POSW(POSW)) u_enc (
        .i_vec    (qin),
        .o_idx    (w_idx),
        .o_onehot (w_oh)
    );

    // One extra bit so pos-1 at 0 and pos+1 at the top never alias.
    assign w_idx_x = {1'b0, w_idx};
    assign w_pos_x = {1'b0, r_pos};
    assign w_fwd   = w_oh && (w_idx_x == w_pos_x + ONE);
    assign w_bwd   = w_oh && (w_idx_x + ONE == w_pos_x);
    assign w_same  = w_oh && (w_idx == r_pos);
    assign w_top   = (w_pos_x == TOP);
    assign w_bot   = (r_pos == '0);

    always_comb begin
        w_state_n  = r_state;
        w_pos_n    = r_pos;
        w_bounce_n = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (w_oh) begin
                    w_state_n = ST_ACQ;
                    w_pos_n   = w_idx;
                end else begin
                    w_state_n = ST_ERR;
                end
            end
            ST_ACQ: begin
                if (w_same) begin
                    w_state_n = ST_ACQ;
                end else if (w_fwd) begin
                    w_state_n = ST_UP;
                    w_pos_n   = w_idx;
                end else if (w_bwd) begin
                    w_state_n = ST_DOWN;
                    w_pos_n   = w_idx;
                end else begin
                    w_state_n = ST_ERR;
                end
            end
            ST_UP: begin
                if (w_same) begin
                    w_state_n = ST_UP;
                end else if (w_fwd) begin
                    w_pos_n = w_idx;
                end else if (w_bwd && w_top) begin
                    w_state_n  = ST_DOWN;
                    w_pos_n    = w_idx;
                    w_bounce_n = 1'b1;
                end else begin
                    w_state_n = ST_ERR;
                end
            end
            ST_DOWN: begin
                if (w_same) begin
                    w_state_n = ST_DOWN;
                end else if (w_bwd) begin
                    w_pos_n = w_idx;
                end else if (w_fwd && w_bot) begin
                    w_state_n  = ST_UP;
                    w_pos_n    = w_idx;
                    w_bounce_n = 1'b1;
                end else begin
                    w_state_n = ST_ERR;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state  <= ST_IDLE;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_valid  <= 1'b0;
            r_bounce <= 1'b0;
            r_sweeps <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pos    <= w_pos_n;
            r_valid  <= (w_state_n == ST_UP) || (w_state_n == ST_DOWN);
            r_bounce <= w_bounce_n;
            r_sweeps <= r_sweeps + {7'd0, w_bounce_n};
            r_err    <= r_err | (w_state_n == ST_ERR);
            if (w_state_n == ST_UP)        r_dir <= 1'b0;
            else if (w_state_n == ST_DOWN) r_dir <= 1'b1;
        end
    end

    assign pos    = r_pos;
    assign dir    = r_dir;
    assign valid  = r_valid;
    assign bounce = r_bounce;
    assign sweeps = r_sweeps;
    assign err    = r_err;

endmodule
